// File: rtl/burst_clock_generator.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | burst_clock_generator: emits N pulses of a 2*H-cycle clock on request,    |
// | with busy/done handshake, edge ticks and completed-pulse counter.         |
// | Optional macro BURST_CLK_ABORT_EN adds the abort input / abort_tick.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module burst_clock_generator #(
  parameter int DIV_WIDTH = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DIV_WIDTH-1:0] half_period,
  input  logic [CNT_WIDTH-1:0] pulse_count,
`ifdef BURST_CLK_ABORT_EN
  input  logic                 abort,
  output logic                 abort_tick,
`endif
  output logic                 clk_out,
  output logic                 rise_tick,
  output logic                 fall_tick,
  output logic                 busy,
  output logic                 done_tick,
  output logic [CNT_WIDTH-1:0] pulse_index
);

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOW_PH  = 2'd1,
    HIGH_PH = 2'd2
  } state_t;

  state_t               state;
  logic [DIV_WIDTH-1:0] h_reg;
  logic [DIV_WIDTH-1:0] phase_cnt;
  logic [CNT_WIDTH-1:0] n_reg;

  logic [DIV_WIDTH-1:0] h_eff;
  logic                 phase_end;
  logic [CNT_WIDTH-1:0] next_index;

  assign h_eff      = (half_period == '0) ? DIV_ONE : half_period;
  assign phase_end  = (phase_cnt == (h_reg - DIV_ONE));
  assign next_index = pulse_index + CNT_ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      h_reg       <= '0;
      n_reg       <= '0;
      phase_cnt   <= '0;
      clk_out     <= 1'b0;
      rise_tick   <= 1'b0;
      fall_tick   <= 1'b0;
      busy        <= 1'b0;
      done_tick   <= 1'b0;
      pulse_index <= '0;
`ifdef BURST_CLK_ABORT_EN
      abort_tick  <= 1'b0;
`endif
    end else begin
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      done_tick <= 1'b0;
`ifdef BURST_CLK_ABORT_EN
      abort_tick <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            h_reg       <= h_eff;
            n_reg       <= pulse_count;
            pulse_index <= '0;
            phase_cnt   <= '0;
            // An empty burst completes on the acceptance edge itself
            if (pulse_count != '0) begin
              state <= LOW_PH;
              busy  <= 1'b1;
            end else begin
              done_tick <= 1'b1;
            end
          end
        end
        LOW_PH: begin
          if (phase_end) begin
            phase_cnt <= '0;
            clk_out   <= 1'b1;
            rise_tick <= 1'b1;
            state     <= HIGH_PH;
          end else begin
            phase_cnt <= phase_cnt + DIV_ONE;
          end
        end
        HIGH_PH: begin
          if (phase_end) begin
            phase_cnt   <= '0;
            clk_out     <= 1'b0;
            fall_tick   <= 1'b1;
            pulse_index <= next_index;
            if (next_index == n_reg) begin
              state     <= IDLE;
              busy      <= 1'b0;
              done_tick <= 1'b1;
            end else begin
              state <= LOW_PH;
            end
          end else begin
            phase_cnt <= phase_cnt + DIV_ONE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef BURST_CLK_ABORT_EN
      // Abort overrides whatever the phase logic scheduled on this edge
      if (abort && (state != IDLE)) begin
        state       <= IDLE;
        phase_cnt   <= '0;
        clk_out     <= 1'b0;
        busy        <= 1'b0;
        rise_tick   <= 1'b0;
        fall_tick   <= 1'b0;
        done_tick   <= 1'b0;
        pulse_index <= pulse_index;
        abort_tick  <= 1'b1;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_burst_clock_generator.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_burst_clock_generator: directed self-checking bench for               |
// | burst_clock_generator. Revision: 1.0                                      |
// +--------------------------------------------------------------------------+
module tb_burst_clock_generator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] half_period = 8'd0;
  logic [3:0] pulse_count = 4'd0;
  logic       clk_out, rise_tick, fall_tick, busy, done_tick;
  logic [3:0] pulse_index;
`ifdef BURST_CLK_ABORT_EN
  logic       abort = 1'b0;
  logic       abort_tick;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] obs;
  logic [8:0] want;

  always #5 clk = ~clk;

  burst_clock_generator #(.DIV_WIDTH(8), .CNT_WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .half_period (half_period),
    .pulse_count (pulse_count),
`ifdef BURST_CLK_ABORT_EN
    .abort       (abort),
    .abort_tick  (abort_tick),
`endif
    .clk_out     (clk_out),
    .rise_tick   (rise_tick),
    .fall_tick   (fall_tick),
    .busy        (busy),
    .done_tick   (done_tick),
    .pulse_index (pulse_index)
  );

  // Expected {clk_out,rise,fall,busy,done,pulse_index} e edges after acceptance
  function automatic logic [8:0] exp_vec(int e, int h, int n);
    logic       c, r, f, b, d;
    logic [3:0] idx;
    int         span;
    span = 2 * n * h;
    c = (e >= h) && (e < span) && ((e / h) % 2 == 1);
    r = (e > 0) && (e < span) && (e % h == 0) && ((e / h) % 2 == 1);
    f = (e > 0) && (e <= span) && (e % h == 0) && ((e / h) % 2 == 0);
    b = (e < span);
    d = (e == span);
    idx = 4'((e / (2 * h) > n) ? n : e / (2 * h));
    return {c, r, f, b, d, idx};
  endfunction

  function automatic logic [8:0] sample();
    return {clk_out, rise_tick, fall_tick, busy, done_tick, pulse_index};
  endfunction

  task automatic launch(input logic [7:0] hp, input logic [3:0] pc);
    @(negedge clk);
    start = 1'b1;
    half_period = hp;
    pulse_count = pc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    obs = sample();
    n_cmp++;
    if (obs !== 9'd0) begin
      n_err++;
      $display("FAIL reset_state got=%b want=%b", obs, 9'd0);
    end
`ifdef BURST_CLK_ABORT_EN
    n_cmp++;
    if (abort_tick !== 1'b0) begin
      n_err++;
      $display("FAIL reset_abort_tick got=%b want=0", abort_tick);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    launch(8'd2, 4'd3);
    for (int e = 0; e <= 14; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      obs = sample(); want = exp_vec(e, 2, 3);
      n_cmp++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL basic_h2n3 e=%0d got=%b want=%b", e, obs, want);
      end
    end
  endtask

  task automatic test_half_zero();
    launch(8'd0, 4'd2);
    for (int e = 0; e <= 6; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      obs = sample(); want = exp_vec(e, 1, 2);
      n_cmp++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL half_zero e=%0d got=%b want=%b", e, obs, want);
      end
    end
  endtask

  task automatic test_zero_count();
    launch(8'd5, 4'd0);
    for (int e = 0; e <= 4; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      obs = sample(); want = exp_vec(e, 5, 0);
      n_cmp++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL zero_count e=%0d got=%b want=%b", e, obs, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    launch(8'd2, 4'd3);
    for (int e = 0; e <= 12; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      obs = sample(); want = exp_vec(e, 2, 3);
      n_cmp++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL busy_ignore e=%0d got=%b want=%b", e, obs, want);
      end
      if (e == 4) begin start = 1'b1; half_period = 8'd7; pulse_count = 4'd1; end
      if (e == 5) start = 1'b0;
      if (e == 12) begin start = 1'b1; half_period = 8'd7; pulse_count = 4'd2; end
    end
    for (int e = 0; e <= 29; e++) begin
      @(posedge clk);
      #1;
      if (e == 0) start = 1'b0;
      obs = sample(); want = exp_vec(e, 7, 2);
      n_cmp++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL back_to_back e=%0d got=%b want=%b", e, obs, want);
      end
    end
  endtask

  task automatic test_async_reset();
    launch(8'd3, 4'd2);
    for (int e = 0; e <= 10; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      obs = sample(); want = exp_vec(e, 3, 2);
      n_cmp++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL pre_reset e=%0d got=%b want=%b", e, obs, want);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    obs = sample();
    n_cmp++;
    if (obs !== 9'd0) begin
      n_err++;
      $display("FAIL async_reset got=%b want=%b", obs, 9'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      obs = sample();
      n_cmp++;
      if (obs !== 9'd0) begin
        n_err++;
        $display("FAIL post_reset_idle c=%0d got=%b want=%b", e, obs, 9'd0);
      end
    end
    launch(8'd1, 4'd1);
    for (int e = 0; e <= 3; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      obs = sample(); want = exp_vec(e, 1, 1);
      n_cmp++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL after_reset e=%0d got=%b want=%b", e, obs, want);
      end
    end
  endtask

`ifdef BURST_CLK_ABORT_EN
  task automatic test_abort();
    launch(8'd3, 4'd4);
    for (int e = 0; e <= 10; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      obs = sample();
      want = (e < 8) ? exp_vec(e, 3, 4) : {5'b00000, 4'd1};
      n_cmp++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL abort_outputs e=%0d got=%b want=%b", e, obs, want);
      end
      n_cmp++;
      if (abort_tick !== (e == 8)) begin
        n_err++;
        $display("FAIL abort_tick e=%0d got=%b want=%b", e, abort_tick, (e == 8));
      end
      // abort stays high through edge 9, where the block is already idle
      if (e == 7) abort = 1'b1;
      if (e == 9) abort = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_half_zero();
    test_zero_count();
    test_back_to_back();
    test_async_reset();
`ifdef BURST_CLK_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
